// File: rtl/get_r_seq_ctrl_pkg.sv
// get_r_pkg: shared constants for the get_R sequencer and its parent.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   MULT_LAT_DEF / ADD_LAT_DEF are also used by the parent that configures the get_R IP cores,
//   so both sides agree on pipeline depth.
package get_r_pkg;

  localparam int MULT_LAT_DEF = 3;
  localparam int ADD_LAT_DEF  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter width for a LAT-cycle run; one spare bit so LAT-1 always fits.
  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/get_r_seq_ctrl_if.sv
// get_r_seq_ctrl_if: operand input port, datapath drive/return and result output port of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the operand side (I_in_valid/O_in_ready) and result side (O_out_valid/I_out_ready).
//   slave  : seen by get_r_seq_ctrl
//   master : seen by the producer/consumer/datapath environment
interface get_r_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 24
);

  logic              I_in_valid;
  logic              O_in_ready;
  logic [DATA_W-1:0] I_a11, I_a12, I_a21, I_a22;
  logic [DATA_W-1:0] I_H11, I_H12, I_H21, I_H22;
  logic [DATA_W-1:0] O_a11, O_a12, O_a21, O_a22;
  logic [DATA_W-1:0] O_H11, O_H12, O_H21, O_H22;
  logic              O_get_r_ena;
  logic [RES_W-1:0]  I_R11, I_R12, I_R21, I_R22;
  logic              O_out_valid;
  logic              I_out_ready;
  logic [RES_W-1:0]  O_R11, O_R12, O_R21, O_R22;
  logic              O_busy;

  modport slave (
    input  I_in_valid, I_a11, I_a12, I_a21, I_a22, I_H11, I_H12, I_H21, I_H22,
    input  I_R11, I_R12, I_R21, I_R22, I_out_ready,
    output O_in_ready, O_a11, O_a12, O_a21, O_a22, O_H11, O_H12, O_H21, O_H22,
    output O_get_r_ena, O_out_valid, O_R11, O_R12, O_R21, O_R22, O_busy
  );

  modport master (
    output I_in_valid, I_a11, I_a12, I_a21, I_a22, I_H11, I_H12, I_H21, I_H22,
    output I_R11, I_R12, I_R21, I_R22, I_out_ready,
    input  O_in_ready, O_a11, O_a12, O_a21, O_a22, O_H11, O_H12, O_H21, O_H22,
    input  O_get_r_ena, O_out_valid, O_R11, O_R12, O_R21, O_R22, O_busy
  );

endinterface

// File: rtl/get_r_seq_ctrl_lat.sv
// get_r_lat_cnt: load/enable down-counter, tc high while the count is zero.
// Latency: load/clr/decrement take effect on the next clock edge; tc is combinational from the count.
// Backpressure: none; en simply pauses the count.
//   Ports: clk, rst_n (async active-low), clr (sync, to zero, highest priority),
//          load/load_val, en (decrement, holds at zero), tc.
module get_r_lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/get_r_seq_ctrl.sv
// get_r_seq_ctrl: sequences one get_R 2x2 product (R = a*H): holds operands, pulses CE for LAT cycles, captures R.
// Latency: accept edge is edge 0, O_out_valid high after edge LAT+1; one op in flight, next accept LAT+3 cycles later.
// Backpressure: O_in_ready only in IDLE; results held in DONE until I_out_ready.
//   Ports: I_sys_clk, I_sys_rstn (async active-low), I_clr (sync abort, top priority), bus (slave modport),
//          O_op_cnt (16-bit saturating completed-op count) only when GET_R_SEQ_PERF_EN is defined.
module get_r_seq_ctrl
  import get_r_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int ADD_LAT  = ADD_LAT_DEF,
  parameter int DATA_W   = 16,
  parameter int RES_W    = 24
) (
  input  logic            I_sys_clk,
  input  logic            I_sys_rstn,
  input  logic            I_clr,
`ifdef GET_R_SEQ_PERF_EN
  output logic [15:0]     O_op_cnt,
`endif
  get_r_seq_ctrl_if.slave bus
);

  localparam int LAT = MULT_LAT + ADD_LAT;
  localparam int CW  = lat_cnt_w(LAT);

  state_t                 state_q, state_d;
  logic                   rdy_en_q;
  logic                   run_done;
  logic                   acc, capt, out_hs;
  logic                   in_rdy, ena, out_vld;
  logic [3:0][DATA_W-1:0] a_q, h_q;
  logic [3:0][RES_W-1:0]  r_q;

  // Keeps O_in_ready low while reset is asserted; IDLE alone would raise it.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) rdy_en_q <= 1'b0;
    else             rdy_en_q <= 1'b1;
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    capt    = 1'b0;
    out_hs  = 1'b0;
    in_rdy  = 1'b0;
    ena     = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_rdy = rdy_en_q;
        if (bus.I_in_valid && rdy_en_q && !I_clr) begin
          acc     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ena = 1'b1;
        if (run_done) state_d = S_CAPT;
      end
      // CE is low here, so the datapath output is frozen while it is sampled.
      S_CAPT: begin
        capt    = !I_clr;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_vld = 1'b1;
        if (bus.I_out_ready) begin
          out_hs  = !I_clr;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (I_clr) state_d = S_IDLE;
  end

  // Loaded with LAT-1 on accept, tc on the last RUN cycle, so RUN lasts exactly LAT cycles.
  get_r_lat_cnt #(.W(CW)) u_lat_cnt (
    .clk      (I_sys_clk),
    .rst_n    (I_sys_rstn),
    .clr      (I_clr),
    .load     (acc),
    .load_val (CW'(LAT - 1)),
    .en       (ena),
    .tc       (run_done)
  );

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      a_q <= '0;
      h_q <= '0;
    end else if (acc) begin
      a_q <= {bus.I_a22, bus.I_a21, bus.I_a12, bus.I_a11};
      h_q <= {bus.I_H22, bus.I_H21, bus.I_H12, bus.I_H11};
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_q <= '0;
    end else if (capt) begin
      r_q <= {bus.I_R22, bus.I_R21, bus.I_R12, bus.I_R11};
    end
  end

`ifdef GET_R_SEQ_PERF_EN
  // Survives I_clr on purpose: it counts delivered results, not sequencer state.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      O_op_cnt <= '0;
    end else if (out_hs && (O_op_cnt != 16'hFFFF)) begin
      O_op_cnt <= O_op_cnt + 16'd1;
    end
  end
`endif

  assign bus.O_in_ready  = in_rdy;
  assign bus.O_get_r_ena = ena;
  assign bus.O_out_valid = out_vld;
  assign bus.O_busy      = (state_q != S_IDLE);
  assign bus.O_a11 = a_q[0];
  assign bus.O_a12 = a_q[1];
  assign bus.O_a21 = a_q[2];
  assign bus.O_a22 = a_q[3];
  assign bus.O_H11 = h_q[0];
  assign bus.O_H12 = h_q[1];
  assign bus.O_H21 = h_q[2];
  assign bus.O_H22 = h_q[3];
  assign bus.O_R11 = r_q[0];
  assign bus.O_R12 = r_q[1];
  assign bus.O_R21 = r_q[2];
  assign bus.O_R22 = r_q[3];

endmodule
